// File: rtl/spi_reg_receiver.sv
// rtl/spi_reg_receiver.sv - SPI mode-0 slave producing single-cycle register write/read strobes
// Define SPI_READBACK_EN to build the read path (RDATA state, tx shifter, spi_miso).
module spi_reg_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_DISCARD
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   rise_q, rise_d;
  logic                   mosi_q, mosi_d;
  logic                   armed_q, armed_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [6:0]             sr_q, sr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   we_q, we_d;

  logic                   sclk_s;
  logic                   cs_s;
  logic [7:0]             rx_byte;
  logic                   byte_done;

`ifdef SPI_READBACK_EN
  logic                   fall_q, fall_d;
  logic                   re_q, re_d;
  logic                   re_dly_q, re_dly_d;
  logic                   first_q, first_d;
  logic                   miso_q, miso_d;
  logic [7:0]             tx_q, tx_d;
`else
  logic                   unused_rdata;
  assign unused_rdata = ^reg_rdata;
`endif

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign rx_byte   = {sr_q, mosi_q};
  assign byte_done = rise_q && (cnt_q == 3'd7);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sclk_prev_d = sclk_s;
    // Edge strobe and mosi are registered together so the sampled bit lines up with its edge.
    rise_d      = sclk_s & ~sclk_prev_q;
    mosi_d      = mosi_sync_q[SYNC_STAGES-1];
    state_d     = state_q;
    armed_d     = armed_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    addr_d      = we_q ? addr_q + ADDR_W'(1) : addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
`ifdef SPI_READBACK_EN
    fall_d      = ~sclk_s & sclk_prev_q;
    re_d        = 1'b0;
    re_dly_d    = re_q;
    first_d     = first_q;
    miso_d      = miso_q;
    tx_d        = tx_q;
    if (re_dly_q) begin
      tx_d    = reg_rdata;
      first_d = 1'b1;
    end
`endif

    if (cs_s) begin
      state_d = S_IDLE;
      armed_d = 1'b1;
      cnt_d   = 3'd0;
`ifdef SPI_READBACK_EN
      miso_d  = 1'b0;
`endif
    end else begin
      // armed_q blocks a transfer already in flight when reset was released.
      case (state_q)
        S_IDLE: begin
          cnt_d = 3'd0;
          if (armed_q) state_d = S_CMD;
        end
        default: begin
          if (rise_q) begin
            sr_d  = rx_byte[6:0];
            cnt_d = cnt_q + 3'd1;
          end
        end
      endcase

      if (byte_done) begin
        case (state_q)
          S_CMD: begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (!rx_byte[7]) begin
              state_d = S_WDATA;
            end else begin
`ifdef SPI_READBACK_EN
              state_d = S_RDATA;
              re_d    = 1'b1;
`else
              state_d = S_DISCARD;
`endif
            end
          end
          S_WDATA: begin
            wdata_d = rx_byte;
            we_d    = 1'b1;
          end
`ifdef SPI_READBACK_EN
          S_RDATA: begin
            addr_d = addr_q + ADDR_W'(1);
            re_d   = 1'b1;
          end
`endif
          default: ;
        endcase
      end

`ifdef SPI_READBACK_EN
      // First falling edge after a load presents tx[7]; later ones shift.
      if (state_q == S_RDATA && fall_q) begin
        if (first_q) begin
          miso_d  = tx_q[7];
          first_d = 1'b0;
        end else begin
          tx_d   = {tx_q[6:0], 1'b0};
          miso_d = tx_q[6];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      mosi_q      <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      sr_q        <= 7'd0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      we_q        <= 1'b0;
`ifdef SPI_READBACK_EN
      fall_q      <= 1'b0;
      re_q        <= 1'b0;
      re_dly_q    <= 1'b0;
      first_q     <= 1'b0;
      miso_q      <= 1'b0;
      tx_q        <= 8'd0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      rise_q      <= rise_d;
      mosi_q      <= mosi_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
`ifdef SPI_READBACK_EN
      fall_q      <= fall_d;
      re_q        <= re_d;
      re_dly_q    <= re_dly_d;
      first_q     <= first_d;
      miso_q      <= miso_d;
      tx_q        <= tx_d;
`endif
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = ~cs_s;
`ifdef SPI_READBACK_EN
  assign reg_re    = re_q;
  assign spi_miso  = miso_q;
`else
  assign reg_re    = 1'b0;
  assign spi_miso  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_receiver.sv
// tb/tb_spi_reg_receiver.sv - scoreboard bench for spi_reg_receiver
// Read-path expectations follow SPI_READBACK_EN.
module tb_spi_reg_receiver;
  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs;
  logic       spi_miso;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  always #5 clk = ~clk;

  spi_reg_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs),
    .spi_miso  (spi_miso),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register file: read data is addr ^ 8'hFF, valid the cycle after reg_re.
  always @(posedge clk) if (reg_re) reg_rdata <= {1'b0, reg_addr} ^ 8'hFF;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         is_wr;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  bit         prev_strobe = 1'b0;
  logic [7:0] tb_bytes [0:7];

  always @(negedge clk) begin
    if (!reset && (reg_we || reg_re)) begin
      check("strobe_overlap", {30'd0, reg_we && reg_re, prev_strobe}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe got we=%0b re=%0b addr=%h wdata=%h want none",
                 reg_we, reg_re, reg_addr, reg_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe_kind", 32'(reg_we), 32'(mon_e.is_wr));
        check("strobe_addr", 32'(reg_addr), 32'(mon_e.addr));
        if (mon_e.is_wr) check("strobe_wdata", 32'(reg_wdata), 32'(mon_e.data));
      end
    end
    prev_strobe = reg_we || reg_re;
  end

  // Reference model: only fully clocked bytes count; address wraps modulo 128.
  task automatic model_push(input int nfull);
    logic [6:0] a;
    exp_t       e;
    a = tb_bytes[0][6:0];
    if (!tb_bytes[0][7]) begin
      for (int i = 1; i < nfull; i++) begin
        e.is_wr = 1'b1;
        e.addr  = a + 7'(i - 1);
        e.data  = tb_bytes[i];
        sb_q.push_back(e);
      end
    end else begin
`ifdef SPI_READBACK_EN
      for (int k = 0; k < nfull; k++) begin
        e.is_wr = 1'b0;
        e.addr  = a + 7'(k);
        e.data  = 8'h00;
        sb_q.push_back(e);
      end
`endif
    end
  endtask

  function automatic logic [7:0] exp_miso(input int i);
`ifdef SPI_READBACK_EN
    logic [6:0] a;
    a = tb_bytes[0][6:0] + 7'(i - 1);
    return {1'b0, a} ^ 8'hFF;
`else
    return 8'h00 & {8{i[0]}};
`endif
  endfunction

  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      #(HALF);
      spi_sclk = 1'b1;
      rd = {rd[6:0], spi_miso};
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_xfer(input int nfull, input int extra);
    logic [7:0] rd;
    model_push(nfull);
    spi_cs = 1'b0;
    #(2*HALF);
    for (int i = 0; i < nfull; i++) begin
      spi_byte(tb_bytes[i], 8, rd);
      if (i > 0 && tb_bytes[0][7]) check("miso_byte", 32'(rd), 32'(exp_miso(i)));
    end
    if (extra > 0) spi_byte(tb_bytes[nfull], extra, rd);
    #(HALF);
    spi_cs = 1'b1;
    #(4*HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},  32'(spi_miso),  32'd0);
    check({tag, "_addr"},  32'(reg_addr),  32'd0);
    check({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    check({tag, "_we"},    32'(reg_we),    32'd0);
    check({tag, "_re"},    32'(reg_re),    32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    int         extra;
    reset     = 1'b1;
    spi_sclk  = 1'b0;
    spi_mosi  = 1'b0;
    spi_cs    = 1'b1;
    reg_rdata = 8'h00;
    #12;
    check_reset_outputs("reset");
    reset = 1'b0;
    #(4*HALF);

    tb_bytes[0] = 8'h05; tb_bytes[1] = 8'hA5;
    run_xfer(2, 0);

    tb_bytes[0] = 8'h7E; tb_bytes[1] = 8'h11; tb_bytes[2] = 8'h22; tb_bytes[3] = 8'h33;
    run_xfer(4, 0);

    tb_bytes[0] = 8'h90; tb_bytes[1] = 8'h00; tb_bytes[2] = 8'h00;
    run_xfer(3, 0);

    tb_bytes[0] = 8'h03; tb_bytes[1] = 8'hC6;
    run_xfer(1, 5);
    tb_bytes[0] = 8'h03; tb_bytes[1] = 8'h5A;
    run_xfer(2, 0);

    tb_bytes[0] = 8'h85; tb_bytes[1] = 8'h12;
    run_xfer(2, 0);

    // Reset three bits into a data byte; the tail of that transfer must be ignored.
    spi_cs = 1'b0;
    #(2*HALF);
    spi_byte(8'h03, 8, rd);
    spi_byte(8'hC3, 3, rd);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    #9;
    reset = 1'b0;
    spi_byte(8'h18, 5, rd);
    spi_byte(8'h77, 8, rd);
    #(HALF);
    spi_cs = 1'b1;
    #(4*HALF);

    tb_bytes[0] = 8'h21; tb_bytes[1] = 8'h9C; tb_bytes[2] = 8'h4D;
    run_xfer(3, 0);

    for (int t = 0; t < 10; t++) begin
      n = 1 + int'($urandom_range(1, 3));
      for (int i = 0; i < 8; i++) tb_bytes[i] = 8'($urandom);
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_xfer(n, extra);
    end

    #1000;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
